// File: rtl/cnn_mac_pipe_sat.sv
// Pipelined signed MAC: (a*b) stream accumulated to in_last, rescaled (floor, or round-half-up with CNN_MAC_ROUND_EN) and saturated.
// Latency: MUL_STAGES+1 cycles from the accepted last pair to out_valid; one pair per cycle.
// Backpressure: out_valid && !out_ready freezes the whole pipeline and drops in_ready.
module cnn_mac_pipe_sat #(
    parameter int A_W        = 14,
    parameter int B_W        = 8,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 14,
    parameter int FRAC_SHIFT = 6,
    parameter int MUL_STAGES = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   in_a,
    input  logic signed [B_W-1:0]   in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic [15:0]             out_beats
);

    localparam int P_W = A_W + B_W;

    generate
        if (ACC_W < A_W + B_W || OUT_W > ACC_W - FRAC_SHIFT || FRAC_SHIFT < 0 ||
            FRAC_SHIFT >= ACC_W || MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_param_err
            $error("cnn_mac_pipe_sat: illegal parameter combination");
        end
    endgenerate

    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic [15:0]             out_beats_q, out_beats_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    first_q, first_d;
    logic [15:0]             beats_q, beats_d;

    logic stall;
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    logic signed [P_W-1:0] mul_c;
    assign mul_c = P_W'(in_a) * P_W'(in_b);

    logic signed [P_W-1:0] p_q [MUL_STAGES];
    logic [MUL_STAGES-1:0] pv_q;
    logic [MUL_STAGES-1:0] pl_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            pv_q <= '0;
            pl_q <= '0;
        end else if (!stall) begin
            pv_q[0] <= in_valid;
            pl_q[0] <= in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    // Product data needs no reset: it is qualified by pv_q everywhere it is used.
    always_ff @(posedge ap_clk) begin
        if (!stall) begin
            p_q[0] <= mul_c;
            for (int i = 1; i < MUL_STAGES; i++) begin
                p_q[i] <= p_q[i-1];
            end
        end
    end

    logic                    tail_vld, tail_last;
    logic signed [ACC_W-1:0] p_ext, acc_base, sum_c;
    logic signed [ACC_W:0]   sum_w, s_c;
    logic [15:0]             beats_inc;

    assign tail_vld  = pv_q[MUL_STAGES-1];
    assign tail_last = pl_q[MUL_STAGES-1];
    assign p_ext     = ACC_W'(p_q[MUL_STAGES-1]);
    assign acc_base  = first_q ? '0 : acc_q;
    assign sum_c     = acc_base + p_ext;
    assign sum_w     = {sum_c[ACC_W-1], sum_c};
    assign beats_inc = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;

`ifdef CNN_MAC_ROUND_EN
    generate
        if (FRAC_SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
            assign s_c = (sum_w + HALF) >>> FRAC_SHIFT;
        end else begin : g_noround
            assign s_c = sum_w;
        end
    endgenerate
`else
    assign s_c = sum_w >>> FRAC_SHIFT;
`endif

    logic signed [OUT_W-1:0] sat_data_c;
    logic                    sat_c;

    always_comb begin
        sat_data_c = s_c[OUT_W-1:0];
        sat_c      = 1'b0;
        if (s_c > OUT_MAX) begin
            sat_data_c = OUT_MAX[OUT_W-1:0];
            sat_c      = 1'b1;
        end else if (s_c < OUT_MIN) begin
            sat_data_c = OUT_MIN[OUT_W-1:0];
            sat_c      = 1'b1;
        end
    end

    // Without a stall the output slot is either idle or being handshaken, so it empties unless refilled.
    always_comb begin
        acc_d       = acc_q;
        first_d     = first_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;
        if (!stall) begin
            out_valid_d = 1'b0;
            if (tail_vld) begin
                if (tail_last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sat_data_c;
                    out_sat_d   = sat_c;
                    out_beats_d = beats_inc;
                    first_d     = 1'b1;
                    beats_d     = 16'd0;
                end else begin
                    acc_d   = sum_c;
                    first_d = 1'b0;
                    beats_d = beats_inc;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            beats_q     <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= 16'd0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// Directed bench for cnn_mac_pipe_sat at default parameters; inputs driven and outputs sampled on the falling edge.
module tb_cnn_mac_pipe_sat;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [13:0] in_a;
    logic signed [7:0]  in_b;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] out_data;
    logic               out_sat;
    logic [15:0]        out_beats;

    int vectors     = 0;
    int miscompares = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_mac_pipe_sat dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_beats(out_beats)
    );

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge ap_clk);
    endtask

    // Presents one pair and holds it until it is accepted; returns on the falling edge after acceptance.
    task automatic send_pair(input int a, input int b, input logic last);
        logic r;
        int   k;
        in_valid = 1'b1;
        in_a     = 14'(a);
        in_b     = 8'(b);
        in_last  = last;
        k        = 0;
        do begin
            r = in_ready;
            @(negedge ap_clk);
            k++;
        end while (!r && k < 50);
        in_valid = 1'b0;
        if (!r) begin
            vectors++;
            miscompares++;
            $display("FAIL send_pair: in_ready stayed 0 for %0d cycles, required 1", k);
        end
    endtask

    task automatic wait_result();
        logic got;
        got      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ap_clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_result: out_valid=%b after 20 cycles, required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge ap_clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        vectors++; if (out_data !== 14'sd0) begin miscompares++; $display("FAIL rst_data: got %0d required 0", out_data); end
        vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL rst_sat: got %b required 0", out_sat); end
        vectors++; if (out_beats !== 16'd0) begin miscompares++; $display("FAIL rst_beats: got %0d required 0", out_beats); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b required 1", in_ready); end
        ap_rst = 1'b0;
        idle(1);
    endtask

    task automatic test_latency();
        send_pair(100, 64, 1'b1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_c1: out_valid got %b required 0", out_valid); end
        @(negedge ap_clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_c2: out_valid got %b required 0", out_valid); end
        @(negedge ap_clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lat_c3: out_valid got %b required 1", out_valid); end
        vectors++; if (out_data !== 14'sd100) begin miscompares++; $display("FAIL lat_data: got %0d required 100", out_data); end
        vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL lat_sat: got %b required 0", out_sat); end
        vectors++; if (out_beats !== 16'd1) begin miscompares++; $display("FAIL lat_beats: got %0d required 1", out_beats); end
        @(negedge ap_clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_drop: out_valid got %b required 0", out_valid); end
    endtask

    task automatic test_saturate();
        idle(2);
        for (int i = 0; i < 4; i++) send_pair(8191, 127, (i == 3));
        wait_result();
        vectors++; if (out_data !== 14'sd8191) begin miscompares++; $display("FAIL sat_hi_data: got %0d required 8191", out_data); end
        vectors++; if (out_sat !== 1'b1) begin miscompares++; $display("FAIL sat_hi_flag: got %b required 1", out_sat); end
        vectors++; if (out_beats !== 16'd4) begin miscompares++; $display("FAIL sat_hi_beats: got %0d required 4", out_beats); end
        send_pair(-8192, 127, 1'b1);
        wait_result();
        vectors++; if (out_data !== 14'(-8192)) begin miscompares++; $display("FAIL sat_lo_data: got %0d required -8192", out_data); end
        vectors++; if (out_sat !== 1'b1) begin miscompares++; $display("FAIL sat_lo_flag: got %b required 1", out_sat); end
        vectors++; if (out_beats !== 16'd1) begin miscompares++; $display("FAIL sat_lo_beats: got %0d required 1", out_beats); end
    endtask

    task automatic test_rounding();
        int ta [4] = '{3, -3, 1, -1};
        int tb [4] = '{11, 11, 32, 32};
        int e_floor [4] = '{0, -1, 0, -1};
        int e_round [4] = '{1, -1, 1, 0};
        int rnd;
`ifdef CNN_MAC_ROUND_EN
        rnd = 1;
`else
        rnd = 0;
`endif
        idle(2);
        for (int i = 0; i < 4; i++) begin
            int e;
            e = (rnd != 0) ? e_round[i] : e_floor[i];
            send_pair(ta[i], tb[i], 1'b1);
            wait_result();
            vectors++;
            if (out_data !== 14'(e)) begin
                miscompares++;
                $display("FAIL round_%0dx%0d: got %0d required %0d", ta[i], tb[i], out_data, e);
            end
            vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL round_sat_%0d: got %b required 0", i, out_sat); end
        end
    endtask

    task automatic test_backpressure();
        idle(2);
        out_ready = 1'b0;
        send_pair(1, 64, 1'b1);
        send_pair(2, 64, 1'b1);
        @(negedge ap_clk);
        in_valid = 1'b1; in_a = 14'sd3; in_b = 8'sd64; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid_%0d: got %b required 1", i, out_valid); end
            vectors++; if (out_data !== 14'sd1) begin miscompares++; $display("FAIL bp_hold_data_%0d: got %0d required 1", i, out_data); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_%0d: got %b required 0", i, in_ready); end
            if (i < 4) @(negedge ap_clk);
        end
        out_ready = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_second_valid: got %b required 1", out_valid); end
        vectors++; if (out_data !== 14'sd2) begin miscompares++; $display("FAIL bp_second_data: got %0d required 2", out_data); end
        vectors++; if (out_beats !== 16'd1) begin miscompares++; $display("FAIL bp_second_beats: got %0d required 1", out_beats); end
        wait_result();
        vectors++; if (out_data !== 14'sd3) begin miscompares++; $display("FAIL bp_third_data: got %0d required 3", out_data); end
    endtask

    task automatic test_bubbles();
        idle(2);
        send_pair(10, 64, 1'b0);
        idle(2);
        send_pair(20, 64, 1'b0);
        idle(3);
        send_pair(30, 64, 1'b1);
        wait_result();
        vectors++; if (out_data !== 14'sd60) begin miscompares++; $display("FAIL bubble_data: got %0d required 60", out_data); end
        vectors++; if (out_beats !== 16'd3) begin miscompares++; $display("FAIL bubble_beats: got %0d required 3", out_beats); end
        vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL bubble_sat: got %b required 0", out_sat); end
    endtask

    task automatic test_back_to_back();
        idle(2);
        for (int i = 0; i < 8; i++) begin
            logic expv;
            expv = (i >= 3 && i <= 6);
            vectors++;
            if (out_valid !== expv) begin miscompares++; $display("FAIL b2b_valid_%0d: got %b required %b", i, out_valid, expv); end
            if (expv) begin
                vectors++;
                if (out_data !== 14'(i - 2)) begin miscompares++; $display("FAIL b2b_data_%0d: got %0d required %0d", i, out_data, i - 2); end
            end
            if (i < 4) begin
                in_valid = 1'b1; in_a = 14'(i + 1); in_b = 8'sd64; in_last = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge ap_clk);
        end
    endtask

    task automatic test_mid_reset();
        idle(2);
        send_pair(7, 64, 1'b0);
        send_pair(9, 64, 1'b0);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_stale_%0d: out_valid got %b required 0", i, out_valid); end
            @(negedge ap_clk);
        end
        send_pair(5, 64, 1'b1);
        wait_result();
        vectors++; if (out_data !== 14'sd5) begin miscompares++; $display("FAIL mrst_data: got %0d required 5", out_data); end
        vectors++; if (out_beats !== 16'd1) begin miscompares++; $display("FAIL mrst_beats: got %0d required 1", out_beats); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_saturate();
        test_rounding();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
